ex_stage: RTL
=============

Name: ex_stage

Overview:
Execute stage of the 5-stage MIPS pipeline, placed between the ID/EX latch and MEM_Stage. It contains:
- the ALU
- the branch-target adder
- the RegDst mux
- an iterative 32-cycle multiplier that owns the HI/LO registers
- the EX/MEM pipeline latch

It produces the registered fields that MEM_Stage packs into its ex_mem bundle. It raises a stall to IF/ID while a multiply result is not yet available.

Parameters:
MUL_CYCLES, 32, iterations of the shift-add multiplier (fixed datapath width is 32).

Ports:
clk  in  1  pipeline clock
reset  in  1  synchronous, active-high reset
id_valid  in  1  ID/EX holds a real instruction
wb_ctrl_in  in  2  {RegWrite, MemtoReg}
m_ctrl_in  in  3  {Branch, MemWrite, MemRead}
alu_op  in  4  ALU function code (package enum)
alu_src  in  1  1 = operand B is sign_ext_imm
reg_dst  in  1  1 = write rd, 0 = write rt
pc_plus4  in  32  PC+4 of the instruction
read_data1  in  32  rs value
read_data2  in  32  rt value
sign_ext_imm  in  32  sign-extended immediate; bits [10:6] are shamt
rt  in  5  rt field
rd  in  5  rd field
flush  in  1  squash the instruction currently in EX (taken branch in MEM)
stall  out  1  hold PC, IF/ID and ID/EX this cycle
ex_valid  out  1  EX/MEM holds a real instruction
wb_ctrl_out  out  2  registered wb_ctrl
m_ctrl_out  out  3  registered m_ctrl
branch_target  out  32  registered pc_plus4 + (imm << 2)
alu_result  out  32  registered ALU/MFHI/MFLO result
zero  out  1  registered (alu_result == 0)
write_data  out  32  registered read_data2 (store data)
write_reg  out  5  registered destination register

Behaviour:
- Reset (synchronous) puts every registered output at 0. It also clears HI/LO and the multiplier state, so an in-flight multiply is abandoned. stall = 0 while reset is high.
- EX/MEM latch has 1-cycle latency. It loads every cycle unless reset is high.
- Bubble insertion: when flush, stall, or !id_valid is true, the latch loads ex_valid = 0 with wb_ctrl_out and m_ctrl_out forced to 0. The data fields are don't-care; the bench must not check them.
- Operand B = alu_src ? sign_ext_imm : read_data2.
- ALU operations:
  - ADD and SUB wrap mod 2^32; no overflow trap.
  - SLT is a signed compare.
  - SLL, SRL and SRA shift operand B by shamt.
  - NOR = ~(A|B).
- zero is computed from the selected result, including MFHI/MFLO results.
- branch_target = pc_plus4 + {sign_ext_imm[29:0], 2'b00}, mod 2^32.
- write_reg = reg_dst ? rd : rt.
- MULT/MULTU start:
  - Accepted when id_valid, !flush and the multiplier is idle.
  - The instruction passes to EX/MEM normally; its wb_ctrl is 0 from the decoder.
  - On the acceptance edge the multiplier latches the operand magnitudes and a sign flag; the sign flag is set for MULT with exactly one negative operand.
  - busy = 1 from the next cycle for MUL_CYCLES cycles of shift-add.
  - On the final iteration edge, HI/LO load the 64-bit product, two's-complement negated if the sign flag is set, and busy falls.
- stall = id_valid & busy & (alu_op is MULT, MULTU, MFHI or MFLO). stall is combinational.
- Instructions that are not multiply-related proceed normally while busy; the multiplier overlaps them.
- An MFHI/MFLO issued in the cycle after busy falls reads the new value.
- Flush rules:
  - flush in the acceptance cycle cancels the multiply; it never starts.
  - flush while busy does not abort the multiply, because the multiply is older than the branch.
  - When flush and stall are both high, flush wins: a bubble is inserted. stall still holds upstream, and ID/EX is overwritten by the front end's own flush.
- MFHI/MFLO while idle: alu_result = HI/LO, written through the normal wb path.

Decomposition:
- Package ex_pkg:
  - alu_op enum: AND=0, OR=1, ADD=2, SLL=3, SRL=4, SRA=5, SUB=6, SLT=7, MULT=8, MULTU=9, MFHI=10, MFLO=11, NOR=12.
  - Control-field widths: WB_W=2, M_W=3.
- One natural sub-module, ex_multiplier:
  - Inputs: start, signed flag, operand A, operand B.
  - Outputs: busy, hi, lo.
  - Owns the counter, sign flag and HI/LO registers.
- The ALU and the muxes stay inline in ex_stage.

Test Plan:
- ADD: read_data1=5, read_data2=7, reg_dst=1, rd=9 -> next cycle alu_result=12, zero=0, write_reg=9, ex_valid=1.
- BEQ-style SUB: rs=rt=0x55, pc_plus4=0x100, imm=0xFFFFFFFE -> zero=1, branch_target=0xF8, m_ctrl_out passed through unchanged.
- MULT: A=-3, B=7, then MFLO in the next slot -> stall high for exactly 32 cycles; then MFLO gives alu_result=0xFFFFFFEB and MFHI gives 0xFFFFFFFF. Independent ADDs issued during busy are not stalled.
- MULTU: 0xFFFFFFFF × 2 -> HI=1, LO=0xFFFFFFFE.
- flush: flush with a valid ADD -> ex_valid=0 and ctrl fields=0. flush in the MULT acceptance cycle -> busy never rises and HI/LO are unchanged.
- reset: reset raised mid-multiply at iteration 10 -> next cycle all outputs 0, busy=0, HI=LO=0; MFHI afterwards returns 0 with no stall.

Source files
------------

// File: rtl/ex_pkg.sv
// ex_pkg: ALU function codes and control-field widths shared by the execute stage
package ex_pkg;
   localparam int WB_W = 2;
   localparam int M_W = 3;
   typedef enum logic [3:0] {
      OP_AND = 4'd0, OP_OR = 4'd1, OP_ADD = 4'd2, OP_SLL = 4'd3, OP_SRL = 4'd4,
      OP_SRA = 4'd5, OP_SUB = 4'd6, OP_SLT = 4'd7, OP_MULT = 4'd8, OP_MULTU = 4'd9,
      OP_MFHI = 4'd10, OP_MFLO = 4'd11, OP_NOR = 4'd12
   } alu_op_t;
   function automatic logic uses_hilo(alu_op_t op);
      return op inside {OP_MULT, OP_MULTU, OP_MFHI, OP_MFLO};
   endfunction
endpackage

// File: rtl/ex_stage_if.sv
// ex_stage_if: ID/EX fields into the execute stage and registered EX/MEM fields out of it
interface ex_stage_if;
   import ex_pkg::*;
   logic id_valid, alu_src, reg_dst, flush, stall, ex_valid, zero;
   logic [WB_W-1:0] wb_ctrl_in, wb_ctrl_out;
   logic [M_W-1:0] m_ctrl_in, m_ctrl_out;
   alu_op_t alu_op;
   logic [31:0] pc_plus4, read_data1, read_data2, sign_ext_imm;
   logic [31:0] branch_target, alu_result, write_data;
   logic [4:0] rt, rd, write_reg;
   modport master (
      output id_valid, wb_ctrl_in, m_ctrl_in, alu_op, alu_src, reg_dst, pc_plus4,
             read_data1, read_data2, sign_ext_imm, rt, rd, flush,
      input  stall, ex_valid, wb_ctrl_out, m_ctrl_out, branch_target, alu_result, zero,
             write_data, write_reg
   );
   modport slave (
      input  id_valid, wb_ctrl_in, m_ctrl_in, alu_op, alu_src, reg_dst, pc_plus4,
             read_data1, read_data2, sign_ext_imm, rt, rd, flush,
      output stall, ex_valid, wb_ctrl_out, m_ctrl_out, branch_target, alu_result, zero,
             write_data, write_reg
   );
endinterface

// File: rtl/ex_multiplier.sv
// ex_multiplier: sign-magnitude shift-add multiplier that owns HI/LO
module ex_multiplier #(parameter int MUL_CYCLES = 32) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        sgn,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);
   localparam int CW = $clog2(MUL_CYCLES);
   logic [CW-1:0] cnt;
   logic neg;
   logic [31:0] mag_a, mag_b, mplier;
   logic [63:0] mcand, acc, acc_next;
   assign mag_a = (sgn & a[31]) ? -a : a;
   assign mag_b = (sgn & b[31]) ? -b : b;
   assign acc_next = acc + (mplier[0] ? mcand : 64'd0);
   always_ff @(posedge clk) begin
      if (reset) begin
         busy <= 1'b0;
         cnt <= '0;
         neg <= 1'b0;
         mcand <= '0;
         mplier <= '0;
         acc <= '0;
         hi <= '0;
         lo <= '0;
      end else if (busy) begin
         acc <= acc_next;
         mcand <= mcand << 1;
         mplier <= mplier >> 1;
         cnt <= cnt + 1'b1;
         if (cnt == CW'(MUL_CYCLES - 1)) begin
            busy <= 1'b0;
            {hi, lo} <= neg ? -acc_next : acc_next;
         end
      end else if (start) begin
         busy <= 1'b1;
         cnt <= '0;
         neg <= sgn & (a[31] ^ b[31]);
         mcand <= {32'd0, mag_a};
         mplier <= mag_b;
         acc <= '0;
      end
   end
endmodule

// File: rtl/ex_stage.sv
// ex_stage: MIPS execute stage with ALU, branch adder, RegDst mux, multiplier and EX/MEM latch
module ex_stage
   import ex_pkg::*;
#(parameter int MUL_CYCLES = 32) (
   input logic clk,
   input logic reset,
   ex_stage_if.slave bus
);
   logic busy, bubble, start;
   logic [31:0] hi, lo, op_b, result;
   logic [4:0] shamt;
   assign start = bus.id_valid & ~bus.flush & ~busy & (bus.alu_op inside {OP_MULT, OP_MULTU});
   assign bus.stall = ~reset & bus.id_valid & busy & uses_hilo(bus.alu_op);
   assign bubble = bus.flush | bus.stall | ~bus.id_valid;
   assign op_b = bus.alu_src ? bus.sign_ext_imm : bus.read_data2;
   assign shamt = bus.sign_ext_imm[10:6];
   always_comb begin
      case (bus.alu_op)
         OP_AND:  result = bus.read_data1 & op_b;
         OP_OR:   result = bus.read_data1 | op_b;
         OP_ADD:  result = bus.read_data1 + op_b;
         OP_SUB:  result = bus.read_data1 - op_b;
         OP_SLT:  result = {31'd0, $signed(bus.read_data1) < $signed(op_b)};
         OP_SLL:  result = op_b << shamt;
         OP_SRL:  result = op_b >> shamt;
         OP_SRA:  result = $signed(op_b) >>> shamt;
         OP_NOR:  result = ~(bus.read_data1 | op_b);
         OP_MFHI: result = hi;
         OP_MFLO: result = lo;
         default: result = '0;
      endcase
   end
   ex_multiplier #(.MUL_CYCLES(MUL_CYCLES)) u_mul (
      .clk(clk),
      .reset(reset),
      .start(start),
      .sgn(bus.alu_op == OP_MULT),
      .a(bus.read_data1),
      .b(bus.read_data2),
      .busy(busy),
      .hi(hi),
      .lo(lo)
   );
   always_ff @(posedge clk) begin
      if (reset) begin
         bus.ex_valid <= 1'b0;
         bus.wb_ctrl_out <= '0;
         bus.m_ctrl_out <= '0;
         bus.branch_target <= '0;
         bus.alu_result <= '0;
         bus.zero <= 1'b0;
         bus.write_data <= '0;
         bus.write_reg <= '0;
      end else begin
         bus.ex_valid <= ~bubble;
         bus.wb_ctrl_out <= bubble ? '0 : bus.wb_ctrl_in;
         bus.m_ctrl_out <= bubble ? '0 : bus.m_ctrl_in;
         bus.branch_target <= bus.pc_plus4 + {bus.sign_ext_imm[29:0], 2'b00};
         bus.alu_result <= result;
         bus.zero <= (result == 32'd0);
         bus.write_data <= bus.read_data2;
         bus.write_reg <= bus.reg_dst ? bus.rd : bus.rt;
      end
   end
endmodule
